// File: rtl/fused_fp_pkg.sv
// Shared types and constants for the fused FP8/FP16/FP32 multiplier scheduler.
package fused_fp_pkg;

    localparam int CFG_BITS   = 2;
    localparam int MANT_W     = 24;
    // Wide enough for any practical requester count; the top slices what it needs.
    localparam int ENTRY_ID_W = 8;

    typedef logic [CFG_BITS-1:0] cfg_t;

    // Mirrors the CONFIG_FP8/16/32 encodings used by the multiplier.
    localparam cfg_t CFG_FP8  = 2'd0;
    localparam cfg_t CFG_FP16 = 2'd1;
    localparam cfg_t CFG_FP32 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SWITCH = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [ENTRY_ID_W-1:0] id;
        cfg_t                  cfg;
        logic [MANT_W-1:0]     data;
    } res_entry_t;

    // Counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fused_sched_fifo.sv
// Result FIFO for the multiplier scheduler; head is presented combinationally.
module fused_sched_fifo
    import fused_fp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  res_entry_t    i_data,
    input  logic          i_pop,
    output res_entry_t    o_head,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    res_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    // A pop frees the head slot, so a simultaneous push at full is still safe.
    assign w_push  = i_push && (!w_full || w_pop);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    // Pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Upstream credit accounting must never let a push reach a full FIFO.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule

// File: rtl/fused_mul_sched.sv
// Round-robin scheduler sharing one fused FP8/16/32 mantissa multiplier
// between N_REQ requesters, with precision-switch bubbles and a credited result FIFO.
module fused_mul_sched
    import fused_fp_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int MUL_LAT    = 0,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CFG_W      = CFG_BITS,   // must match the package cfg_t width
    localparam int IDW        = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][CFG_W-1:0]    req_cfg,
    input  logic [N_REQ-1:0][MANT_W-1:0]   req_in1,
    input  logic [N_REQ-1:0][MANT_W-1:0]   req_in2,
    output logic [MANT_W-1:0]              mul_in1,
    output logic [MANT_W-1:0]              mul_in2,
    output logic [CFG_W-1:0]               mul_cfg,
    input  logic [MANT_W-1:0]              mul_out,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [IDW-1:0]                 res_id,
    output logic [CFG_W-1:0]               res_cfg,
    output logic [MANT_W-1:0]              res_data,
    output logic                           busy,
    output logic [15:0]                    stat_sw
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_e   r_state;
    cfg_t           r_cur_cfg;
    logic [IDW-1:0] r_rr_ptr;
    logic           r_lock_v;
    logic [IDW-1:0] r_lock_id;
    logic [15:0]    r_stat_sw;

    logic           w_rr_found;
    logic [IDW-1:0] w_rr_idx;
    logic           w_cand_v;
    logic [IDW-1:0] w_cand_id;
    cfg_t           w_cand_cfg;
    logic [IDW-1:0] w_rr_next;
    logic           w_credit;
    logic           w_act;
    logic           w_issue;
    logic           w_switch;

    logic           w_push;
    logic [IDW-1:0] w_push_id;
    cfg_t           w_push_cfg;
    res_entry_t     w_push_ent;
    logic [15:0]    w_inflight;
    logic           w_tag_any;

    logic           w_pop;
    logic           w_fifo_empty;
    logic [CW-1:0]  w_fifo_cnt;
    res_entry_t     w_head;
    logic           w_unused_head_id;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (32'(r_rr_ptr) + 32'(k)) % 32'(N_REQ);
            if (!w_rr_found && req_valid[idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDW'(idx);
            end
        end
    end

    // A requester locked by a precision switch wins ahead of the RR order.
    always_comb begin
        if (r_lock_v && req_valid[r_lock_id]) begin
            w_cand_v  = 1'b1;
            w_cand_id = r_lock_id;
        end else begin
            w_cand_v  = w_rr_found;
            w_cand_id = w_rr_idx;
        end
    end

    assign w_cand_cfg = req_cfg[w_cand_id];
    assign w_rr_next  = (w_cand_id == IDW'(N_REQ-1)) ? '0 : w_cand_id + 1'b1;
    // Ops in the multiplier already own a FIFO slot, so count them too.
    assign w_credit   = (32'(w_inflight) + 32'(w_fifo_cnt)) < 32'(FIFO_DEPTH);
    assign w_act      = !rst && (r_state != ST_SWITCH) && w_cand_v;
    assign w_issue    = w_act && (w_cand_cfg == r_cur_cfg) && w_credit;
    assign w_switch   = w_act && (w_cand_cfg != r_cur_cfg);

    // Grant and operand steering; operands read as zero whenever nothing issues.
    always_comb begin
        req_ready = '0;
        mul_in1   = '0;
        mul_in2   = '0;
        if (w_issue) begin
            req_ready[w_cand_id] = 1'b1;
            mul_in1              = req_in1[w_cand_id];
            mul_in2              = req_in2[w_cand_id];
        end
    end

    // Scheduler FSM: issue, or lock the winner and spend one cycle switching precision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cur_cfg <= CFG_FP32;
            r_rr_ptr  <= '0;
            r_lock_v  <= 1'b0;
            r_lock_id <= '0;
            r_stat_sw <= '0;
        end else begin
            unique case (r_state)
                ST_SWITCH: r_state <= ST_IDLE;
                default: begin
                    if (w_switch) begin
                        r_state   <= ST_SWITCH;
                        r_cur_cfg <= w_cand_cfg;
                        r_lock_v  <= 1'b1;
                        r_lock_id <= w_cand_id;
                        r_stat_sw <= sat_inc16(r_stat_sw);
                    end else if (w_issue) begin
                        r_state   <= ST_ISSUE;
                        r_rr_ptr  <= w_rr_next;
                        r_lock_v  <= 1'b0;
                    end else begin
                        r_state   <= ST_IDLE;
                        // A locked requester that withdrew gives up its priority.
                        if (r_lock_v && !req_valid[r_lock_id]) r_lock_v <= 1'b0;
                    end
                end
            endcase
        end
    end

    generate
        if (MUL_LAT == 0) begin : g_comb_mul
            // Combinational multiplier: the product is captured on the issue edge.
            assign w_push     = w_issue;
            assign w_push_id  = w_cand_id;
            assign w_push_cfg = w_cand_cfg;
            assign w_inflight = '0;
            assign w_tag_any  = 1'b0;
        end else begin : g_tag_pipe
            logic [MUL_LAT-1:0]                r_tag_v;
            logic [MUL_LAT-1:0][IDW-1:0]       r_tag_id;
            logic [MUL_LAT-1:0][CFG_BITS-1:0]  r_tag_cfg;

            // Tag pipe tracks which op the multiplier output belongs to.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_v   <= '0;
                    r_tag_id  <= '0;
                    r_tag_cfg <= '0;
                end else begin
                    r_tag_v[0]   <= w_issue;
                    r_tag_id[0]  <= w_cand_id;
                    r_tag_cfg[0] <= w_cand_cfg;
                    for (int s = 1; s < MUL_LAT; s++) begin
                        r_tag_v[s]   <= r_tag_v[s-1];
                        r_tag_id[s]  <= r_tag_id[s-1];
                        r_tag_cfg[s] <= r_tag_cfg[s-1];
                    end
                end
            end

            assign w_push     = r_tag_v[MUL_LAT-1];
            assign w_push_id  = r_tag_id[MUL_LAT-1];
            assign w_push_cfg = r_tag_cfg[MUL_LAT-1];
            assign w_inflight = 16'($countones(r_tag_v));
            assign w_tag_any  = |r_tag_v;
        end
    endgenerate

    // Pack the exiting op into a FIFO entry.
    always_comb begin
        w_push_ent      = '0;
        w_push_ent.id   = ENTRY_ID_W'(w_push_id);
        w_push_ent.cfg  = w_push_cfg;
        w_push_ent.data = mul_out;
    end

    assign w_pop = res_valid && res_ready;

    fused_sched_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_ent),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    assign res_valid        = !w_fifo_empty;
    assign res_id           = w_head.id[IDW-1:0];
    assign res_cfg          = w_head.cfg;
    assign res_data         = w_head.data;
    assign w_unused_head_id = ^w_head.id;

    assign mul_cfg = r_cur_cfg;
    assign stat_sw = r_stat_sw;
    assign busy    = w_tag_any | (w_fifo_cnt != '0) | (r_state == ST_SWITCH);

endmodule

// File: tb/tb_fused_mul_sched.sv
// Scoreboard bench for fused_mul_sched with a behavioural multiplier stand-in (MUL_LAT=0).
module tb_fused_mul_sched;
    import fused_fp_pkg::*;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][1:0]     req_cfg;
    logic [N-1:0][23:0]    req_in1;
    logic [N-1:0][23:0]    req_in2;
    logic [23:0]           mul_in1;
    logic [23:0]           mul_in2;
    logic [1:0]            mul_cfg;
    logic [23:0]           mul_out;
    logic                  res_valid;
    logic                  res_ready;
    logic [1:0]            res_id;
    logic [1:0]            res_cfg;
    logic [23:0]           res_data;
    logic                  busy;
    logic [15:0]           stat_sw;

    int                    n_chk = 0;
    int                    n_err = 0;
    int                    n_iss = 0;
    int                    rem [N];
    logic [N-1:0]          gnt;
    res_entry_t            sb [$];

    always #5 clk = ~clk;

    fused_mul_sched #(
        .N_REQ      (N),
        .MUL_LAT    (0),
        .FIFO_DEPTH (4),
        .CFG_W      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cfg   (req_cfg),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_cfg   (mul_cfg),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_cfg   (res_cfg),
        .res_data  (res_data),
        .busy      (busy),
        .stat_sw   (stat_sw)
    );

    // Normalised mantissa product, truncated to the precision's mantissa width.
    function automatic logic [23:0] mul_ref(input logic [23:0] a, input logic [23:0] b,
                                            input logic [1:0] c);
        logic [47:0] p;
        logic [23:0] n;
        p = {24'd0, a} * {24'd0, b};
        n = p[47] ? p[47:24] : p[46:23];
        if (c == CFG_FP16) n[12:0] = '0;
        else if (c == CFG_FP8) n[19:0] = '0;
        return n;
    endfunction

    assign mul_out = mul_ref(mul_in1, mul_in2, mul_cfg);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic new_ops(input int i);
        req_in1[i] = {1'b1, 23'($urandom)};
        req_in2[i] = {1'b1, 23'($urandom)};
    endtask

    task automatic start(input int i, input logic [1:0] c, input int n);
        rem[i]       = n;
        req_cfg[i]   = c;
        new_ops(i);
        req_valid[i] = 1'b1;
    endtask

    // Sample on the falling edge: record grants into the scoreboard, check popped results.
    task automatic smp();
        res_entry_t e;
        @(negedge clk);
        gnt = req_ready;
        chk("rdy_onehot", 32'($onehot0(req_ready)), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                e.id   = 8'(i);
                e.cfg  = req_cfg[i];
                e.data = mul_ref(req_in1[i], req_in2[i], req_cfg[i]);
                sb.push_back(e);
                n_iss++;
            end
        end
        if (res_valid && res_ready) begin
            chk("sb_has_exp", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_id",   32'(res_id),   32'(e.id));
                chk("res_cfg",  32'(res_cfg),  32'(e.cfg));
                chk("res_data", 32'(res_data), 32'(e.data));
            end
        end
    endtask

    // Advance past the rising edge and let granted requesters move on.
    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                rem[i]--;
                if (rem[i] <= 0) req_valid[i] = 1'b0;
                else new_ops(i);
            end
        end
        gnt = '0;
    endtask

    task automatic step();
        smp();
        adv();
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && sb.size() != 0; k++) step();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        gnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog n_chk %0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        int n4;
        rst       = 1'b1;
        req_valid = '0;
        req_cfg   = '0;
        req_in1   = '0;
        req_in2   = '0;
        res_ready = 1'b1;
        gnt       = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset state, with a request pending that must not be granted.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_cfg[0]   = CFG_FP32;
        req_in1[0]   = 24'h123456;
        req_in2[0]   = 24'h876543;
        @(negedge clk);
        chk("rst_ready",   32'(req_ready), 32'd0);
        chk("rst_mul_in1", 32'(mul_in1),   32'd0);
        chk("rst_res_vld", 32'(res_valid), 32'd0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_mul_cfg", 32'(mul_cfg),   32'(CFG_FP32));
        chk("rst_stat_sw", 32'(stat_sw),   32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // 1: 1.5 * 1.5 on requester 0.
        rem[0] = 1; req_cfg[0] = CFG_FP32;
        req_in1[0] = 24'hC00000; req_in2[0] = 24'hC00000; req_valid[0] = 1'b1;
        smp();
        chk("t1_ready",   32'(gnt),     32'h1);
        chk("t1_mul_in1", 32'(mul_in1), 32'hC00000);
        chk("t1_mul_cfg", 32'(mul_cfg), 32'(CFG_FP32));
        adv();
        smp();
        chk("t1_res_vld",  32'(res_valid), 32'd1);
        chk("t1_res_id",   32'(res_id),    32'd0);
        chk("t1_res_data", 32'(res_data),  32'h900000);
        adv();
        smp();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        adv();

        // 2: two same-precision streams alternate from a fresh RR pointer.
        do_reset();
        start(0, CFG_FP32, 4);
        start(1, CFG_FP32, 4);
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("t2_grant", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            adv();
        end
        drain("t2_drain");
        chk("t2_stat_sw", 32'(stat_sw), 32'd0);

        // 3: FP32 op followed by an FP16 request -> one switch bubble.
        start(2, CFG_FP32, 1);
        smp();
        chk("t3_fp32", 32'(gnt), 32'h4);
        adv();
        start(3, CFG_FP16, 1);
        smp();
        chk("t3_decide", 32'(gnt), 32'h0);
        adv();
        smp();
        chk("t3_sw_ready",  32'(gnt),     32'h0);
        chk("t3_sw_cfg",    32'(mul_cfg), 32'(CFG_FP16));
        chk("t3_sw_in1",    32'(mul_in1), 32'd0);
        chk("t3_sw_busy",   32'(busy),    32'd1);
        chk("t3_stat_sw",   32'(stat_sw), 32'd1);
        adv();
        smp();
        chk("t3_fp16_issue", 32'(gnt), 32'h8);
        adv();
        drain("t3_drain");

        // 3b: the locked winner beats the RR pointer after the switch.
        start(1, CFG_FP8, 1);
        smp();
        chk("t3b_decide", 32'(gnt), 32'h0);
        adv();
        start(0, CFG_FP8, 1);
        smp();
        chk("t3b_sw_ready", 32'(gnt),     32'h0);
        chk("t3b_sw_cfg",   32'(mul_cfg), 32'(CFG_FP8));
        adv();
        smp();
        chk("t3b_lock", 32'(gnt), 32'h2);
        adv();
        smp();
        chk("t3b_next", 32'(gnt), 32'h1);
        adv();
        chk("t3b_stat_sw", 32'(stat_sw), 32'd2);
        drain("t3b_drain");

        // 4: back-pressure with all four streaming; credit caps issues at the FIFO depth.
        res_ready = 1'b0;
        n4 = 0;
        for (int i = 0; i < N; i++) start(i, CFG_FP8, 2);
        for (int k = 0; k < 10; k++) begin
            smp();
            n4 += $countones(gnt);
            if (k >= 4) begin
                chk("t4_no_ready", 32'(gnt), 32'h0);
                chk("t4_hold_id",   32'(res_id),   32'(sb[0].id));
                chk("t4_hold_data", 32'(res_data), 32'(sb[0].data));
            end
            adv();
        end
        chk("t4_issues", 32'(n4), 32'd4);
        chk("t4_busy",   32'(busy), 32'd1);
        res_ready = 1'b1;
        drain("t4_drain");
        chk("t4_all_done", 32'(req_valid), 32'h0);

        // 5: reset with results buffered drops them.
        res_ready = 1'b0;
        start(0, CFG_FP8, 1);
        start(1, CFG_FP8, 1);
        repeat (3) step();
        smp();
        chk("t5_pre_vld", 32'(res_valid), 32'd1);
        adv();
        do_reset();
        smp();
        chk("t5_res_vld", 32'(res_valid), 32'd0);
        chk("t5_busy",    32'(busy),      32'd0);
        chk("t5_mul_cfg", 32'(mul_cfg),   32'(CFG_FP32));
        chk("t5_stat_sw", 32'(stat_sw),   32'd0);
        adv();
        res_ready = 1'b1;

        // 6: push+pop at DEPTH-1 keeps the count; at full the credit blocks even while popping.
        res_ready = 1'b0;
        start(0, CFG_FP32, 3);
        repeat (3) step();
        res_ready = 1'b1;
        start(1, CFG_FP32, 1);
        smp();
        chk("t6_issue_at_3", 32'(gnt),       32'h2);
        chk("t6_pop_at_3",   32'(res_valid), 32'd1);
        adv();
        res_ready = 1'b0;
        start(2, CFG_FP32, 1);
        smp();
        chk("t6_fill", 32'(gnt), 32'h4);
        adv();
        start(3, CFG_FP32, 1);
        smp();
        chk("t6_full_block", 32'(gnt), 32'h0);
        adv();
        res_ready = 1'b1;
        smp();
        chk("t6_full_pop_block", 32'(gnt), 32'h0);
        adv();
        smp();
        chk("t6_after_pop", 32'(gnt), 32'h8);
        adv();
        drain("t6_drain");
        smp();
        chk("t6_idle_busy", 32'(busy), 32'd0);
        adv();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
